aes_decrypt_ctrl: RTL and testbench
===================================

AES_DECRYPT_CTRL -- requirements
Module: aes_decrypt_ctrl

Interface
REQ-001 The block SHALL have parameter NR, default 10, meaning the number of AES rounds; legal values are 10, 12 and 14.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-004 Port in_valid, input, 1 bit, SHALL mean a ciphertext block is offered.
REQ-005 Port in_ready, output, 1 bit, SHALL mean the block can accept a ciphertext.
REQ-006 Port ciphertext, input, 128 bits, SHALL carry the block; it is sampled only on accept.
REQ-007 Port key_idx, output, 4 bits, SHALL be the round-key index requested this cycle.
REQ-008 Port round_key, input, 128 bits, SHALL be the key for key_idx, valid combinationally in the same cycle.
REQ-009 Port out_valid, output, 1 bit, SHALL mean plaintext is valid.
REQ-010 Port out_ready, input, 1 bit, SHALL mean the consumer takes the plaintext.
REQ-011 Port plaintext, output, 128 bits, SHALL carry the decrypted block.
REQ-012 Port busy, output, 1 bit, SHALL be high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, ROUND, FINAL and DONE.
REQ-014 IDLE behaviour:
- in_ready = 1 and key_idx = NR.
- Accept occurs when in_valid && in_ready.
- On accept: state register <= ciphertext ^ round_key; cnt <= NR-1; go to ROUND.
REQ-015 ROUND behaviour, one cycle per round:
- key_idx = cnt.
- state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ round_key).
- cnt decrements.
- When cnt == 1, go to FINAL with cnt <= 0.
REQ-016 FINAL behaviour:
- key_idx = 0.
- state <= InvSubBytes(InvShiftRows(state)) ^ round_key, with no InvMixColumns.
- Go to DONE.
REQ-017 Latency SHALL be exactly NR cycles: out_valid rises NR rising edges after the accept edge (10 for NR=10).
REQ-018 DONE behaviour:
- out_valid = 1; plaintext equals the state register.
- On out_valid && out_ready, return to IDLE.
- If out_ready stays low, hold indefinitely with plaintext stable.
REQ-019 in_ready SHALL be 0 in ROUND, FINAL and DONE; in_valid in those states SHALL be ignored and SHALL NOT corrupt the state register.
REQ-020 A new block SHALL NOT be accepted in the same cycle as the DONE handshake; in_ready rises in the following cycle. Sustained throughput is one block per NR+2 cycles.
REQ-021 key_idx SHALL be a combinational decode of FSM state and cnt, with no added latency; in DONE, key_idx = NR.
REQ-022 cnt SHALL be 4 bits wide, SHALL never wrap below 0, and SHALL be don't-care outside ROUND and FINAL.
REQ-023 plaintext SHALL be driven from the state register in all states; it is meaningful only while out_valid = 1.

Reset
REQ-024 With rst high at a clock edge, the next state SHALL be IDLE, cnt = 0, out_valid = 0, in_ready = 1, busy = 0, and the state register = 128'h0.
REQ-025 rst SHALL take priority over any simultaneous accept or output handshake.
REQ-026 A reset in mid-operation SHALL abort the block in progress with no output produced.
REQ-027 Reset SHALL have no asynchronous path.

Structure
REQ-028 The FSM state encoding, the NR legal values and the AES width constants (128-bit block, 4-bit key index) SHALL live in a shared package, aes_pkg.
REQ-029 The round datapath SHALL be one combinational sub-module, aes_inv_round, with:
- inputs: state, round_key, final_round;
- output: the next state;
- composition: the existing InvShiftRows, InvSubBytes and InvMixColumns blocks.
REQ-030 aes_decrypt_ctrl SHALL contain only the FSM, the counter, the 128-bit state register and the handshake logic.

Verification
REQ-031 FIPS-197 C.1 vector, NR=10, key 000102030405060708090a0b0c0d0e0f: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a SHALL produce plaintext 00112233445566778899aabbccddeeff, with out_valid rising exactly 10 edges after accept.
REQ-032 key_idx trace: key_idx SHALL equal 10 in the accept cycle, then 9, 8, ..., 1, then 0, then 10 in DONE.
REQ-033 Backpressure: holding out_ready = 0 for 20 cycles SHALL keep out_valid = 1 and plaintext stable; out_ready = 1 SHALL then complete the handshake and make in_ready = 1 on the next cycle.
REQ-034 Busy input: in_valid held high with a different ciphertext throughout ROUND SHALL leave the C.1 result unchanged, and in_ready SHALL stay 0.
REQ-035 Reset mid-operation: rst asserted at round 5 SHALL give, next cycle, IDLE, out_valid = 0, in_ready = 1 and state = 0; a following C.1 decrypt SHALL complete correctly.
REQ-036 Back-to-back: two blocks offered with out_ready tied to 1 SHALL both produce correct plaintexts, with accepts exactly NR+2 = 12 cycles apart.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES widths, round-count values, decrypt FSM encoding and the
// inverse-cipher byte transforms (InvShiftRows, InvSubBytes, InvMixColumns).
package aes_pkg;

    localparam int BLOCK_W   = 128;
    localparam int KEY_IDX_W = 4;

    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;

    typedef logic [BLOCK_W-1:0]   block_t;
    typedef logic [KEY_IDX_W-1:0] key_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } dec_state_t;

    function automatic bit nr_is_legal(input int nr);
        return (nr == NR_AES128) || (nr == NR_AES192) || (nr == NR_AES256);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    // Inverse affine map followed by field inversion.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] y;
        for (int i = 0; i < 8; i++) begin
            y[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8];
        end
        y = y ^ 8'h05;
        return gf_inv(y);
    endfunction

    // Byte i of a block sits at bits [127-8i -: 8]; byte r+4c is row r, column c.
    function automatic block_t inv_shift_rows(input block_t s);
        block_t o;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[8*(15 - (r + 4*((c + r) % 4))) +: 8] = s[8*(15 - (r + 4*c)) +: 8];
            end
        end
        return o;
    endfunction

    function automatic block_t inv_sub_bytes(input block_t s);
        block_t o;
        for (int i = 0; i < 16; i++) begin
            o[8*(15 - i) +: 8] = inv_sbox(s[8*(15 - i) +: 8]);
        end
        return o;
    endfunction

    function automatic block_t inv_mix_columns(input block_t s);
        block_t     o;
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a[r]  = s[8*(15 - (4*c + r)) +: 8];
                x2    = xtime(a[r]);
                x4    = xtime(x2);
                x8    = xtime(x4);
                m9[r] = x8 ^ a[r];
                mb[r] = x8 ^ x2 ^ a[r];
                md[r] = x8 ^ x4 ^ a[r];
                me[r] = x8 ^ x4 ^ x2;
            end
            o[8*(15 - (4*c + 0)) +: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
            o[8*(15 - (4*c + 1)) +: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
            o[8*(15 - (4*c + 2)) +: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
            o[8*(15 - (4*c + 3)) +: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse-cipher round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless final.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is registered.
module aes_inv_round
    import aes_pkg::*;
(
    input  block_t state,
    input  block_t round_key,
    input  logic   final_round,
    output block_t next_state
);

    block_t sub_shifted;
    block_t keyed;

    assign sub_shifted = inv_sub_bytes(inv_shift_rows(state));
    assign keyed       = sub_shifted ^ round_key;
    assign next_state  = final_round ? keyed : inv_mix_columns(keyed);

endmodule

// File: rtl/aes_decrypt_ctrl.sv
// Iterative AES block decryptor: FSM, round counter, 128-bit state register and handshakes.
// Latency: out_valid rises NR clock edges after the accept edge; one block per NR+2 cycles.
// Backpressure: plaintext holds in DONE until out_ready; in_ready is low outside IDLE.
module aes_decrypt_ctrl
    import aes_pkg::*;
#(
    parameter int NR = NR_AES128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BLOCK_W-1:0]   ciphertext,
    output logic [KEY_IDX_W-1:0] key_idx,
    input  logic [BLOCK_W-1:0]   round_key,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BLOCK_W-1:0]   plaintext,
    output logic                 busy
);

    if (!nr_is_legal(NR)) begin : g_bad_nr
        $error("aes_decrypt_ctrl: NR must be 10, 12 or 14");
    end

    localparam key_idx_t KEY_LAST  = key_idx_t'(NR);
    localparam key_idx_t CNT_FIRST = key_idx_t'(NR - 1);

    dec_state_t fsm_q, fsm_d;
    key_idx_t   cnt_q, cnt_d;
    block_t     blk_q, blk_d;
    block_t     round_out;
    logic       final_round;

    aes_inv_round u_round (
        .state       (blk_q),
        .round_key   (round_key),
        .final_round (final_round),
        .next_state  (round_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q <= IDLE;
            cnt_q <= '0;
            blk_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            cnt_q <= cnt_d;
            blk_q <= blk_d;
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        cnt_d       = cnt_q;
        blk_d       = blk_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        key_idx     = KEY_LAST;
        final_round = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    blk_d = ciphertext ^ round_key;
                    cnt_d = CNT_FIRST;
                    fsm_d = ROUND;
                end
            end
            ROUND: begin
                key_idx = cnt_q;
                blk_d   = round_out;
                // Round 1 is the last mixing round; the counter stops at zero.
                if (cnt_q == key_idx_t'(1)) begin
                    cnt_d = '0;
                    fsm_d = FINAL;
                end else begin
                    cnt_d = cnt_q - key_idx_t'(1);
                end
            end
            FINAL: begin
                key_idx     = '0;
                final_round = 1'b1;
                blk_d       = round_out;
                fsm_d       = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign busy      = (fsm_q != IDLE);
    assign plaintext = blk_q;

endmodule

// File: tb/tb_aes_decrypt_ctrl.sv
// Bench for aes_decrypt_ctrl: a forward AES-128 model builds ciphertexts from random
// plaintexts and serves the round keys; the DUT must recover the plaintext on schedule.
module tb_aes_decrypt_ctrl;

    localparam int NR = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ciphertext;
    logic [3:0]   key_idx;
    logic [127:0] round_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plaintext;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox   [0:255];
    logic [31:0]  w      [0:43];
    logic [127:0] rk_tab [0:15];

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

    aes_decrypt_ctrl #(.NR(NR)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .key_idx    (key_idx),
        .round_key  (round_key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Key memory answers the requested index in the same cycle.
    assign round_key = rk_tab[key_idx];

    // ---------------- reference model: forward AES-128 ----------------
    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
        return prod[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) if (tb_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] enc_round(input logic [127:0] s, input bit mix);
        logic [7:0]   st [16];
        logic [7:0]   sh [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) st[i] = sbox[s[8*(15-i) +: 8]];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) sh[r + 4*c] = st[r + 4*((c + r) % 4)];
        for (int c = 0; c < 4; c++) begin
            if (mix) begin
                o[8*(15-(4*c+0)) +: 8] = tb_mul(sh[4*c],8'h02) ^ tb_mul(sh[4*c+1],8'h03) ^ sh[4*c+2] ^ sh[4*c+3];
                o[8*(15-(4*c+1)) +: 8] = sh[4*c] ^ tb_mul(sh[4*c+1],8'h02) ^ tb_mul(sh[4*c+2],8'h03) ^ sh[4*c+3];
                o[8*(15-(4*c+2)) +: 8] = sh[4*c] ^ sh[4*c+1] ^ tb_mul(sh[4*c+2],8'h02) ^ tb_mul(sh[4*c+3],8'h03);
                o[8*(15-(4*c+3)) +: 8] = tb_mul(sh[4*c],8'h03) ^ sh[4*c+1] ^ sh[4*c+2] ^ tb_mul(sh[4*c+3],8'h02);
            end else begin
                for (int r = 0; r < 4; r++) o[8*(15-(4*c+r)) +: 8] = sh[4*c+r];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk_tab[0];
        for (int r = 1; r <= NR; r++) s = enc_round(s, r != NR) ^ rk_tab[r];
        return s;
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[32*(3-i) +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
                rcon = tb_mul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk_tab[r] = (r <= NR) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_blk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one block in IDLE, trace the key schedule, stall DONE, then hand off.
    task automatic decrypt(input string tag, input logic [127:0] ct, input logic [127:0] exp,
                           input int stall, input bit noisy);
        check_bit({tag, ".idle_rdy"}, in_ready, 1'b1);
        check_blk({tag, ".kidx_acc"}, 128'(key_idx), 128'(NR));
        in_valid   = 1'b1;
        ciphertext = ct;
        out_ready  = 1'b0;
        tick();
        in_valid = noisy;
        for (int k = NR - 1; k >= 0; k--) begin
            if (noisy) ciphertext = rand128();
            check_blk($sformatf("%s.kidx%0d", tag, k), 128'(key_idx), 128'(k));
            check_bit($sformatf("%s.rdy%0d", tag, k), in_ready, 1'b0);
            check_bit($sformatf("%s.ov%0d", tag, k), out_valid, 1'b0);
            check_bit($sformatf("%s.busy%0d", tag, k), busy, 1'b1);
            tick();
        end
        in_valid = 1'b0;
        check_bit({tag, ".ov_at_nr"}, out_valid, 1'b1);
        check_blk({tag, ".kidx_done"}, 128'(key_idx), 128'(NR));
        check_bit({tag, ".rdy_done"}, in_ready, 1'b0);
        check_blk({tag, ".pt"}, plaintext, exp);
        for (int i = 0; i < stall; i++) begin
            tick();
            check_bit($sformatf("%s.hold_ov%0d", tag, i), out_valid, 1'b1);
            check_blk($sformatf("%s.hold_pt%0d", tag, i), plaintext, exp);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_bit({tag, ".post_ov"}, out_valid, 1'b0);
        check_bit({tag, ".post_rdy"}, in_ready, 1'b1);
        check_bit({tag, ".post_busy"}, busy, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] pt_a, pt_b, ct_a, ct_b;
        logic [127:0] got [2];
        int           acc_cyc [2];
        int           n_acc, n_out;
        bit           acc_now;

        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        ciphertext = '0;
        for (int x = 0; x < 256; x++) sbox[x] = sbox_calc(8'(x));
        expand_key(C1_KEY);

        tick();
        tick();
        check_bit("rst.in_ready", in_ready, 1'b1);
        check_bit("rst.out_valid", out_valid, 1'b0);
        check_bit("rst.busy", busy, 1'b0);
        check_blk("rst.state", plaintext, 128'h0);
        check_blk("rst.key_idx", 128'(key_idx), 128'(NR));

        // Reset wins over an accept offered in the same cycle.
        in_valid   = 1'b1;
        ciphertext = C1_CT;
        tick();
        check_bit("rst_vs_acc.busy", busy, 1'b0);
        check_blk("rst_vs_acc.state", plaintext, 128'h0);
        in_valid = 1'b0;
        rst      = 1'b0;

        decrypt("c1", C1_CT, C1_PT, 0, 1'b0);
        decrypt("c1_bp20", C1_CT, C1_PT, 20, 1'b0);
        decrypt("c1_noisy", C1_CT, C1_PT, 0, 1'b1);

        // Abort at round 5, then the next block must still decrypt correctly.
        in_valid   = 1'b1;
        ciphertext = C1_CT;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check_bit("mid.busy_before", busy, 1'b1);
        rst = 1'b1;
        tick();
        check_bit("mid.out_valid", out_valid, 1'b0);
        check_bit("mid.in_ready", in_ready, 1'b1);
        check_bit("mid.busy", busy, 1'b0);
        check_blk("mid.state", plaintext, 128'h0);
        rst = 1'b0;
        decrypt("c1_after_rst", C1_CT, C1_PT, 0, 1'b0);

        for (int n = 0; n < 4; n++) begin
            pt_a = rand128();
            decrypt($sformatf("rnd%0d", n), aes_encrypt(pt_a), pt_a,
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Back-to-back with out_ready tied high.
        pt_a = rand128();
        pt_b = rand128();
        ct_a = aes_encrypt(pt_a);
        ct_b = aes_encrypt(pt_b);
        n_acc      = 0;
        n_out      = 0;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        ciphertext = ct_a;
        for (int cyc = 0; cyc < 60 && n_out < 2; cyc++) begin
            acc_now = in_valid && in_ready;
            if (out_valid) begin
                got[n_out] = plaintext;
                n_out++;
            end
            tick();
            if (acc_now && n_acc < 2) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                if (n_acc == 1) ciphertext = ct_b;
                else in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_blk("b2b.accepts", 128'(n_acc), 128'd2);
        check_blk("b2b.outputs", 128'(n_out), 128'd2);
        if (n_acc == 2) check_blk("b2b.gap", 128'(acc_cyc[1] - acc_cyc[0]), 128'(NR + 2));
        if (n_out == 2) begin
            check_blk("b2b.pt0", got[0], pt_a);
            check_blk("b2b.pt1", got[1], pt_b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
